sockit_ghrd_onchip_mem_tester: RTL and testbench
================================================

// Module: sockit_ghrd_onchip_mem_tester
// PURPOSE
//  Avalon-MM host that drives the FPGA on-chip RAM slave (64-bit data, 13-bit word address, byteenable,
//  chipselect, write, clken; fixed 1-cycle read latency, no waitrequest). Fills a word range with a
//  deterministic pattern and/or reads it back and compares. Used as a bring-up/BIST engine beside the
//  on-chip memory; a CSR wrapper drives the control side.
// PARAMETERS
//  ADDR_W    13   word address width; address wraps modulo 2**ADDR_W
//  DATA_W    64   data width; must be 64 (pattern is two 32-bit halves)
//  ERRCNT_W  16   width of saturating error counter
// PORTS
//  clk             in   1        single clock
//  reset           in   1        asynchronous, active-high reset
//  start           in   1        1-cycle pulse; sampled only in IDLE/DONE
//  mode            in   2        00 fill, 01 check, 10 fill then check, 11 reserved (treated as 00)
//  base_addr       in   ADDR_W   first word address
//  word_count      in   ADDR_W+1 words to process, 0..2**ADDR_W; 0 = no access
//  seed            in   32       pattern seed
//  pause           in   1        freezes engine and memory (drives clken low)
//  busy            out  1        engine active
//  done            out  1        level; set on completion, cleared by next accepted start
//  error           out  1        sticky; >=1 miscompare in last check
//  error_count     out  ERRCNT_W saturating miscompare count
//  first_err_addr  out  ADDR_W   address of first miscompare
//  avm_address     out  ADDR_W   memory word address
//  avm_byteenable  out  8        always 8'hFF while chipselect high, else 0
//  avm_chipselect  out  1        access strobe
//  avm_write       out  1        1 = write, 0 = read
//  avm_writedata   out  DATA_W   write data
//  avm_readdata    in   DATA_W   read data, valid 1 enabled cycle after read address
//  avm_clken       out  1        = ~pause
// BEHAVIOUR
//  Reset: state IDLE; busy, done, error, chipselect, write, byteenable, error_count, first_err_addr,
//   address, writedata all 0; avm_clken 1. Reset mid-operation aborts immediately (chipselect drops
//   asynchronously); no partial results kept.
//  Pattern for word index i (0-based from base): P(i) = {S, ~S}, S = seed + i (32-bit, wraps).
//  Address for index i = (base_addr + i) mod 2**ADDR_W.
//  FSM: IDLE -> (start) latch inputs, clear error/count/first_err_addr, done=0 ->
//   FILL (modes 00/10/11) or CHECK (01). word_count==0: go straight to DONE next cycle, no access.
//  FILL: one write per unpaused cycle, i = 0..N-1; chipselect=write=1. After last write:
//   mode 10 -> CHECK (i restarts at 0, next cycle); else -> DONE.
//  CHECK: one read per unpaused cycle (chipselect=1, write=0), i = 0..N-1, then DRAIN for 1 cycle.
//   Compare pipeline: cycle after an unpaused read of index i, compare avm_readdata against P(i).
//   Compare is suppressed while pause=1 and resumes with the same expected word (readdata held by
//   memory since clken=0).
//  DRAIN: performs final compare, no access; -> DONE.
//  DONE: done=1, busy=0; start re-enters as from IDLE.
//  busy=1 in FILL/CHECK/DRAIN and in the IDLE->DONE cycle for N=0.
//  Miscompare: error=1; error_count+1 saturating at all-ones; first_err_addr captured only on first.
//  pause: while high, chipselect, address, write, writedata held, index frozen, avm_clken=0.
//  start while busy ignored. Inputs other than pause/avm_readdata sampled only at accepted start.
//  Throughput: N words in N (fill) / N+1 (check) unpaused cycles; fill->check handover adds 0 idle.
// TESTING
//  1 mode=10, base=0, N=4, seed=0x1000: writes 0..3 = {0x1000+i, ~}, reads match; done after 4+4+1
//    cycles, error=0, count=0.
//  2 mode=01 on memory preloaded with word 5 corrupted, base=0, N=8: error=1, count=1,
//    first_err_addr=5.
//  3 mode=00, base=0x1FFE, N=4: addresses 0x1FFE,0x1FFF,0x0000,0x0001; seed=0xFFFFFFFF -> S wraps to 0.
//  4 mode=10, N=16, pause high 3 cycles mid-check: clken=0 for 3 cycles, no false errors, done 3 cycles late.
//  5 N=0: no chipselect, done after 1 cycle; start during busy ignored; N=8192 covers full array.
//  6 reset asserted mid-fill: chipselect/busy drop without clock; outputs at reset values.

Source files
------------

// File: rtl/sockit_ghrd_onchip_mem_tester.sv
// sockit_ghrd_onchip_mem_tester
//   Avalon-MM host / BIST engine for the on-chip RAM (1-cycle read latency,
//   no waitrequest). Fills a word range with the pattern {S, ~S}, S = seed + i,
//   reads it back and compares, or does both.
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   start, mode, base_addr,
//   word_count, seed        operation request, sampled on an accepted start
//   pause                   freezes engine and memory (avm_clken = ~pause)
//   busy, done, error,
//   error_count,
//   first_err_addr          status
//   avm_*                   Avalon-MM host interface to the on-chip RAM
module sockit_ghrd_onchip_mem_tester #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 64,
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     word_count,
  input  logic [31:0]         seed,
  input  logic                pause,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ERRCNT_W-1:0] error_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [7:0]          avm_byteenable,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  output logic                avm_clken
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SKIP,   // single busy cycle for a zero-length request
    S_FILL,
    S_CHECK,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W:0]       idx_q, idx_d;
  logic [ADDR_W:0]       n_q;
  logic [ADDR_W-1:0]     base_q;
  logic [31:0]           seed_q;
  logic                  fill_chk_q;
  logic                  pend_q;
  logic [DATA_W-1:0]     exp_q;
  logic [ADDR_W-1:0]     cmp_addr_q;
  logic                  error_q;
  logic [ERRCNT_W-1:0]   errcnt_q;
  logic [ADDR_W-1:0]     first_q;

  logic                  accept;
  logic                  last;
  logic                  mismatch;
  logic [ADDR_W-1:0]     cur_addr;
  logic [31:0]           s_cur;
  logic [DATA_W-1:0]     pat;

  assign last     = (idx_q == n_q - (ADDR_W+1)'(1));
  assign cur_addr = base_q + idx_q[ADDR_W-1:0];
  assign s_cur    = seed_q + 32'(idx_q);
  assign pat      = {s_cur, ~s_cur};

  // Read data belongs to the read issued in the previous enabled cycle; a
  // paused cycle keeps both the memory output and the pending expectation.
  assign mismatch = pend_q && !pause && (avm_readdata != exp_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    accept  = 1'b0;
    if (!pause) begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            accept = 1'b1;
            idx_d  = '0;
            if (word_count == '0)   state_d = S_SKIP;
            else if (mode == 2'b01) state_d = S_CHECK;
            else                    state_d = S_FILL;
          end
        end
        S_SKIP:  state_d = S_DONE;
        S_FILL: begin
          if (last) begin
            idx_d   = '0;
            state_d = fill_chk_q ? S_CHECK : S_DONE;
          end else begin
            idx_d = idx_q + (ADDR_W+1)'(1);
          end
        end
        S_CHECK: begin
          if (last) state_d = S_DRAIN;
          else      idx_d   = idx_q + (ADDR_W+1)'(1);
        end
        S_DRAIN: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    avm_chipselect = (state_q == S_FILL) || (state_q == S_CHECK);
    avm_write      = (state_q == S_FILL);
    avm_address    = avm_chipselect ? cur_addr : '0;
    avm_writedata  = avm_write ? pat : '0;
    avm_byteenable = avm_chipselect ? 8'hFF : 8'h00;
    avm_clken      = ~pause;
    busy           = (state_q == S_SKIP) || (state_q == S_FILL) ||
                     (state_q == S_CHECK) || (state_q == S_DRAIN);
    done           = (state_q == S_DONE);
  end

  assign error          = error_q;
  assign error_count    = errcnt_q;
  assign first_err_addr = first_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      n_q        <= '0;
      base_q     <= '0;
      seed_q     <= '0;
      fill_chk_q <= 1'b0;
      pend_q     <= 1'b0;
      exp_q      <= '0;
      cmp_addr_q <= '0;
      error_q    <= 1'b0;
      errcnt_q   <= '0;
      first_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        base_q     <= base_addr;
        n_q        <= word_count;
        seed_q     <= seed;
        fill_chk_q <= (mode == 2'b10);
        error_q    <= 1'b0;
        errcnt_q   <= '0;
        first_q    <= '0;
      end else if (mismatch) begin
        error_q <= 1'b1;
        if (errcnt_q != '1) errcnt_q <= errcnt_q + ERRCNT_W'(1);
        if (!error_q)       first_q  <= cmp_addr_q;
      end
      if (!pause) begin
        pend_q     <= (state_q == S_CHECK);
        exp_q      <= pat;
        cmp_addr_q <= cur_addr;
      end
    end
  end

endmodule

// File: tb/tb_sockit_ghrd_onchip_mem_tester.sv
// Bench for sockit_ghrd_onchip_mem_tester: a behavioural RAM, a table of
// directed operations plus randomized operations, each checked against a
// reference model of the expected memory contents, timing and error status.
module tb_sockit_ghrd_onchip_mem_tester;
  localparam int AW    = 13;
  localparam int DW    = 64;
  localparam int EW    = 6;
  localparam int DEPTH = 8192;
  localparam int SAT   = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    mode;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic [31:0]   seed;
  logic          pause;
  logic          busy, done, error;
  logic [EW-1:0] error_count;
  logic [AW-1:0] first_err_addr;
  logic [AW-1:0] avm_address;
  logic [7:0]    avm_byteenable;
  logic          avm_chipselect, avm_write;
  logic [DW-1:0] avm_writedata;
  logic [DW-1:0] avm_readdata;
  logic          avm_clken;

  sockit_ghrd_onchip_mem_tester #(.ADDR_W(AW), .DATA_W(DW), .ERRCNT_W(EW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr),
    .word_count(word_count), .seed(seed), .pause(pause), .busy(busy), .done(done),
    .error(error), .error_count(error_count), .first_err_addr(first_err_addr),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .avm_clken(avm_clken)
  );

  always #5 clk = ~clk;

  // Behavioural on-chip RAM with a side port for test setup.
  logic [63:0]   mem [DEPTH];
  logic          tb_clr, tb_wr_en;
  logic [AW-1:0] tb_wr_addr;
  logic [63:0]   tb_wr_data;

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      avm_readdata <= '0;
    end else if (tb_wr_en) begin
      mem[tb_wr_addr] <= tb_wr_data;
    end else if (avm_clken && avm_chipselect) begin
      if (avm_write) mem[avm_address] <= avm_writedata;
      else           avm_readdata     <= mem[avm_address];
    end
  end

  // Reference model state
  logic [63:0] ref_mem [DEPTH];
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  mode;
    int          base;
    int          n;
    logic [31:0] seed;
    int          corrupt;    // address to corrupt before the run, -1 none
    int          pause_at;   // pause during loop cycles (pause_at, pause_at+pause_len]
    int          pause_len;
    bit          mid;        // pulse start while busy
    bit          auto_exp;   // expected fields come from the model
    int          exp_cycles; // unpaused cycles from accepted start to done
    bit          exp_err;
    int          exp_cnt;
    int          exp_first;
  } vec_t;

  function automatic logic [63:0] pat(input logic [31:0] s0, input int i);
    logic [31:0] s;
    s = s0 + 32'(i);
    return {s, ~s};
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic poke(input int a, input logic [63:0] d);
    @(negedge clk);
    tb_wr_en = 1'b1; tb_wr_addr = AW'(a); tb_wr_data = d;
    @(negedge clk);
    tb_wr_en = 1'b0;
    ref_mem[a] = d;
  endtask

  function automatic int exp_acc(input vec_t v);
    if (v.n == 0) return 0;
    if (v.mode == 2'b01) return v.n;
    if (v.mode == 2'b10) return 2 * v.n;
    return v.n;
  endfunction

  function automatic void model(inout vec_t v);
    int cnt, a;
    cnt = 0;
    v.exp_first = 0;
    if (v.n == 0)             v.exp_cycles = 1;
    else if (v.mode == 2'b01) v.exp_cycles = v.n + 1;
    else if (v.mode == 2'b10) v.exp_cycles = 2 * v.n + 1;
    else                      v.exp_cycles = v.n;
    if (v.mode == 2'b01) begin
      for (int i = 0; i < v.n; i++) begin
        a = (v.base + i) % DEPTH;
        if (ref_mem[a] != pat(v.seed, i)) begin
          if (cnt == 0) v.exp_first = a;
          cnt++;
        end
      end
    end
    v.exp_cnt = (cnt > SAT) ? SAT : cnt;
    v.exp_err = (cnt > 0);
  endfunction

  task automatic run_vec(input vec_t vin, input bit rand_pause, input int tag);
    vec_t v;
    int cyc, pauses, acc, bad;
    string t;
    v = vin;
    t = $sformatf("op%0d", tag);
    if (v.corrupt >= 0) poke(v.corrupt, ref_mem[v.corrupt] ^ 64'h1);
    if (v.auto_exp) model(v);
    @(negedge clk);
    mode = v.mode; base_addr = AW'(v.base); word_count = (AW+1)'(v.n);
    seed = v.seed; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Inputs must have been latched; scramble them.
    mode = 2'($urandom); base_addr = AW'($urandom); word_count = (AW+1)'($urandom);
    seed = $urandom;
    cyc = 0; pauses = 0; acc = 0; bad = 0;
    while (!done && cyc < 40000) begin
      cyc++;
      if (rand_pause) pause = ($urandom_range(0, 4) == 0);
      else            pause = (v.pause_len > 0) && (cyc > v.pause_at) &&
                              (cyc <= v.pause_at + v.pause_len);
      if (v.mid && cyc == 2) begin
        start = 1'b1; mode = 2'($urandom); base_addr = AW'($urandom);
        word_count = (AW+1)'($urandom_range(0, 50)); seed = $urandom;
      end else begin
        start = 1'b0;
      end
      #1;
      if (avm_clken != !pause) bad++;
      if (avm_byteenable != (avm_chipselect ? 8'hFF : 8'h00)) bad++;
      if (avm_chipselect && !pause) acc++;
      if (pause) pauses++;
      @(negedge clk);
    end
    pause = 1'b0; start = 1'b0;
    check({t, " done"}, done, 1);
    check({t, " busy"}, busy, 0);
    check({t, " cycles"}, cyc, v.exp_cycles + pauses);
    check({t, " accesses"}, acc, exp_acc(v));
    check({t, " strobes"}, bad, 0);
    check({t, " error"}, error, v.exp_err);
    check({t, " error_count"}, error_count, v.exp_cnt);
    check({t, " first_err_addr"}, first_err_addr, v.exp_first);
    if (v.mode != 2'b01)
      for (int i = 0; i < v.n; i++) ref_mem[(v.base + i) % DEPTH] = pat(v.seed, i);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] != ref_mem[i]) bad++;
    check({t, " memory words differing"}, bad, 0);
  endtask

  vec_t tbl [9];
  vec_t rv;

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; mode = '0; base_addr = '0;
    word_count = '0; seed = '0; tb_wr_en = 1'b0; tb_wr_addr = '0; tb_wr_data = '0;
    tb_clr = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    //           mode   base    n     seed          corr pat plen mid auto cyc  err cnt first
    tbl[0] = '{2'b10, 0,      4,    32'h0000_1000, -1, 0,  0,  0,  0,   9,   0,  0,  0};
    tbl[1] = '{2'b00, 0,      8,    32'h0000_1000, -1, 0,  0,  0,  0,   8,   0,  0,  0};
    tbl[2] = '{2'b01, 0,      8,    32'h0000_1000,  5, 0,  0,  0,  0,   9,   1,  1,  5};
    tbl[3] = '{2'b00, 'h1FFE, 4,    32'hFFFF_FFFF, -1, 0,  0,  0,  0,   4,   0,  0,  0};
    tbl[4] = '{2'b10, 'h40,   16,   32'hABCD_0000, -1, 20, 3,  0,  0,   33,  0,  0,  0};
    tbl[5] = '{2'b10, 7,      0,    32'h1234_5678, -1, 0,  0,  0,  0,   1,   0,  0,  0};
    tbl[6] = '{2'b11, 'h100,  32,   32'h0000_0077, -1, 0,  0,  1,  0,   32,  0,  0,  0};
    tbl[7] = '{2'b10, 'h1234, 8192, 32'hDEAD_0000, -1, 0,  0,  0,  0,   16385, 0, 0, 0};
    tbl[8] = '{2'b01, 0,      8192, 32'hDEAD_0001, -1, 0,  0,  0,  0,   8193, 1, SAT, 0};

    repeat (2) @(negedge clk);
    tb_clr = 1'b0;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset error", error, 0);
    check("reset error_count", error_count, 0);
    check("reset first_err_addr", first_err_addr, 0);
    check("reset chipselect", avm_chipselect, 0);
    check("reset write", avm_write, 0);
    check("reset byteenable", avm_byteenable, 0);
    check("reset address", avm_address, 0);
    check("reset writedata", avm_writedata, 0);
    check("reset clken", avm_clken, 1);
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 9; k++) begin
      run_vec(tbl[k], 1'b0, k);
      if (k == 3) begin
        check("wrap word 0x1FFF", mem[13'h1FFF], {32'h0, 32'hFFFF_FFFF});
        check("wrap word 0x0001", mem[1], {32'h2, ~32'h2});
      end
    end

    for (int k = 0; k < 24; k++) begin
      rv.mode = 2'($urandom);
      rv.base = $urandom_range(0, DEPTH - 1);
      rv.n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
      rv.seed = $urandom;
      if (k % 3 == 0) begin
        // re-check a freshly known region with optional corruption
        rv.mode = 2'b01;
        rv.seed = ref_mem[rv.base][63:32];
      end
      rv.corrupt = (rv.n > 0 && $urandom_range(0, 1) == 1) ?
                   (rv.base + $urandom_range(0, rv.n - 1)) % DEPTH : -1;
      rv.pause_at = 0; rv.pause_len = 0;
      rv.mid = $urandom_range(0, 1);
      rv.auto_exp = 1'b1;
      rv.exp_cycles = 0; rv.exp_err = 0; rv.exp_cnt = 0; rv.exp_first = 0;
      run_vec(rv, 1'b1, 100 + k);
    end

    // Reset in the middle of a fill must drop the strobe without a clock edge.
    @(negedge clk);
    mode = 2'b00; base_addr = 13'd100; word_count = 14'd200; seed = 32'h42; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("midfill chipselect before reset", avm_chipselect, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midfill reset chipselect", avm_chipselect, 0);
    check("midfill reset busy", busy, 0);
    check("midfill reset write", avm_write, 0);
    check("midfill reset address", avm_address, 0);
    check("midfill reset writedata", avm_writedata, 0);
    check("midfill reset byteenable", avm_byteenable, 0);
    check("midfill reset done", done, 0);
    check("midfill reset error_count", error_count, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("after reset stays idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
